// File: rtl/multicycle_control.sv
// Main sequencer for the multi-cycle DLX datapath (fetch/decode/execute/memory/write-back).
// Optional performance counters are enabled by defining MULTICYCLE_PERF_EN.
module multicycle_control #(
  parameter int unsigned PERF_W   = 32,
  parameter int unsigned LINK_REG = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [4:0] link_reg,
  output logic       illegal_op
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [PERF_W-1:0] instr_count,
  output logic [PERF_W-1:0] cycle_count
`endif
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR,
    EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP
  } state_t;

  state_t state, next_state, dispatch;
  logic   sel_q, sel_d, illegal_d, illegal_q;

  if (PERF_W < 8) begin : g_perf_w_check
    $error("multicycle_control: PERF_W must be at least 8");
  end

  // sel_q carries the one opcode-dependent variant bit per class
  // (SW vs LW, rd vs rt, BNEZ vs BEQZ, JAL vs J) so later states stay Moore.
  always_comb begin
    dispatch  = FETCH;
    sel_d     = 1'b0;
    illegal_d = 1'b0;
    case (opcode)
      6'h00:                      begin dispatch = EXEC_R;  sel_d = 1'b1;      end
      6'h23:                      begin dispatch = MEMADDR; sel_d = 1'b0;      end
      6'h2b:                      begin dispatch = MEMADDR; sel_d = 1'b1;      end
      6'h04, 6'h05:               begin dispatch = BRANCH;  sel_d = opcode[0]; end
      6'h02, 6'h03:               begin dispatch = JUMP;    sel_d = opcode[0]; end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h14,
      6'h16, 6'h17, 6'h18, 6'h19, 6'h1a, 6'h1c:
                                  begin dispatch = EXEC_I;  sel_d = 1'b0;      end
      default:                    illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state     <= next_state;
      illegal_q <= (state == DECODE) && illegal_d;
      if (state == DECODE) sel_q <= sel_d;
    end
  end

  always_comb begin
    next_state    = state;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = 2'b00;
    alu_op        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    case (state)
      IDLE: next_state = FETCH;
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b01;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) next_state = DECODE;
      end
      DECODE: begin
        alu_src_b  = 2'b10;
        next_state = dispatch;
      end
      MEMADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = sel_q ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) next_state = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        next_state = FETCH;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) next_state = FETCH;
      end
      EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        next_state = ALUWB;
      end
      EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_op     = 2'b10;
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = {1'b0, sel_q};
        next_state = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = sel_q;
        next_state    = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        if (sel_q) begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
        next_state = FETCH;
      end
      default: next_state = IDLE;
    endcase
  end

  assign link_reg   = 5'(LINK_REG);
  assign illegal_op = illegal_q;

`ifdef MULTICYCLE_PERF_EN
  logic instr_done;
  assign instr_done = (next_state == FETCH) && (state != FETCH) && (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= '0;
      cycle_count <= '0;
    end else begin
      if (instr_done)    instr_count <= instr_count + 1'b1;
      if (state != IDLE) cycle_count <= cycle_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: random instruction stream with a random-latency memory.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, branch_ne;
  logic [1:0] pc_source, alu_op, alu_src_b, reg_dst, mem_to_reg;
  logic       alu_src_a, reg_write, illegal_op;
  logic [4:0] link_reg;
`ifdef MULTICYCLE_PERF_EN
  logic [31:0] instr_count, cycle_count;
`endif

  multicycle_control #(.PERF_W(32), .LINK_REG(31)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_source(pc_source), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .link_reg(link_reg), .illegal_op(illegal_op)
`ifdef MULTICYCLE_PERF_EN
    , .instr_count(instr_count), .cycle_count(cycle_count)
`endif
  );

  always #5 clk = ~clk;

  logic [19:0] outs;
  assign outs = {mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, branch_ne,
                 pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst,
                 mem_to_reg, illegal_op};

  typedef struct {
    int cyc; int irw; int pcw; int pcwc; int bne; int regw;
    int dst; int src; int memw; int ill; int aluop2; int aluop1;
  } rec_t;

  rec_t exp_q[$];
  int   passed = 0;
  int   total  = 0;
  int   done_cnt = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
  endtask

  function automatic bit is_itype(input logic [5:0] op);
    return (op >= 6'h08 && op <= 6'h0e) || op == 6'h14 ||
           (op >= 6'h16 && op <= 6'h1a) || op == 6'h1c;
  endfunction

  // Expected observable effect of one instruction, from fetch start to the next fetch start.
  function automatic rec_t expect_of(input logic [5:0] op, input int fw, input int dw);
    rec_t r = '{default: 0};
    r.irw = 1;
    r.pcw = 1;
    if (op == 6'h00) begin
      r.cyc = 4 + fw; r.regw = 1; r.dst = 1; r.aluop2 = 1;
    end else if (op == 6'h23) begin
      r.cyc = 5 + fw + dw; r.regw = 1; r.src = 1;
    end else if (op == 6'h2b) begin
      r.cyc = 4 + fw + dw; r.memw = dw + 1;
    end else if (op == 6'h04 || op == 6'h05) begin
      r.cyc = 3 + fw; r.pcwc = 1; r.bne = int'(op[0]); r.aluop1 = 1;
    end else if (op == 6'h02 || op == 6'h03) begin
      r.cyc = 3 + fw; r.pcw = 2;
      if (op[0]) begin r.regw = 1; r.dst = 2; r.src = 2; end
    end else if (is_itype(op)) begin
      r.cyc = 4 + fw; r.regw = 1; r.aluop2 = 1;
    end else begin
      r.cyc = 2 + fw; r.ill = 1;
    end
    return r;
  endfunction

  task automatic compare(input rec_t o);
    rec_t e;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk("cycles", o.cyc, e.cyc);
    chk("ir_write_cnt", o.irw, e.irw);
    chk("pc_write_cnt", o.pcw, e.pcw);
    chk("pc_write_cond_cnt", o.pcwc, e.pcwc);
    chk("branch_ne", o.bne, e.bne);
    chk("reg_write_cnt", o.regw, e.regw);
    chk("reg_dst", o.dst, e.dst);
    chk("mem_to_reg", o.src, e.src);
    chk("mem_write_cycles", o.memw, e.memw);
    chk("illegal_pulses", o.ill, e.ill);
    chk("alu_op_funct_cycles", o.aluop2, e.aluop2);
    chk("alu_op_cmp_cycles", o.aluop1, e.aluop1);
  endtask

  // Monitor: a fetch start (request with iord=0) closes the previous instruction window.
  initial begin
    rec_t obs = '{default: 0};
    bit   open = 1'b0, prev_f = 1'b0, is_f, start;
    forever begin
      @(negedge clk); #3;
      if (mon_en && !rst) begin
        is_f  = mem_req && !iord && !mem_write;
        start = is_f && !prev_f;
        if (start) begin
          if (open) begin
            obs.ill += int'(illegal_op);
            compare(obs);
            done_cnt++;
          end
          open = 1'b1;
          obs  = '{default: 0};
        end
        if (open) begin
          obs.cyc++;
          if (!start) obs.ill += int'(illegal_op);
          obs.irw  += int'(ir_write);
          obs.pcw  += int'(pc_write);
          obs.pcwc += int'(pc_write_cond);
          if (pc_write_cond) obs.bne = int'(branch_ne);
          if (reg_write) begin
            obs.regw++;
            obs.dst = int'(reg_dst);
            obs.src = int'(mem_to_reg);
          end
          obs.memw   += int'(mem_write);
          obs.aluop2 += int'(alu_op == 2'b10);
          obs.aluop1 += int'(alu_op == 2'b01);
        end
        prev_f = is_f;
      end
    end
  end

  task automatic summary_and_fatal();
    $display("%0d/%0d checks passed", passed, total);
    $fatal(1, "bench aborted");
  endtask

  // Called at a negedge; returns at the negedge where the wanted request is visible.
  task automatic wait_req(input logic want_iord);
    for (int i = 0; i < 64; i++) begin
      if (mem_req && iord == want_iord) return;
      mem_ready = 1'($urandom);
      @(negedge clk);
    end
    chk(want_iord ? "timeout_data_req" : "timeout_fetch_req", 0, 1);
    summary_and_fatal();
  endtask

  task automatic serve(input int waits);
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'($urandom);
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int dw);
    wait_req(1'b0);
    opcode = op;
    exp_q.push_back(expect_of(op, fw, dw));
    serve(fw);
    @(negedge clk);
    opcode = 6'($urandom);
    if (op == 6'h23 || op == 6'h2b) begin
      wait_req(1'b1);
      serve(dw);
    end
  endtask

  initial begin
    logic [5:0] op;
    int         cls;
    rst = 1'b1; mem_ready = 1'b0; opcode = 6'h00;
    #3;
    chk("reset_outputs", int'(outs), 0);
    chk("link_reg", int'(link_reg), 31);
    @(negedge clk); rst = 1'b0;
    #1 chk("idle_outputs", int'(outs), 0);
    @(negedge clk);
    chk("fetch_req", int'({mem_req, iord}), 2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("abort_outputs", int'(outs), 0);
    @(negedge clk); rst = 1'b0; mon_en = 1'b1;
    #1 chk("idle_after_abort", int'(outs), 0);
    @(negedge clk);
    chk("fetch_after_idle", int'({mem_req, iord, mem_write}), 4);

    run_instr(6'h00, 0, 0);
    run_instr(6'h23, 0, 2);
    run_instr(6'h2b, 1, 1);
    run_instr(6'h05, 0, 0);
    run_instr(6'h04, 2, 0);
    run_instr(6'h03, 0, 0);
    run_instr(6'h02, 0, 0);
    run_instr(6'h3f, 0, 0);
    run_instr(6'h0a, 0, 0);
    for (int n = 0; n < 60; n++) begin
      cls = $urandom_range(0, 9);
      case (cls)
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2b;
        3: op = 6'($urandom_range(4, 5));
        4: op = 6'($urandom_range(2, 3));
        5: op = 6'($urandom_range(8, 14));
        6: op = 6'($urandom_range(22, 26));
        default: op = 6'($urandom);
      endcase
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    wait_req(1'b0);
    mem_ready = 1'b0;
    @(negedge clk); #4;
    chk("scoreboard_drained", exp_q.size(), 0);
`ifdef MULTICYCLE_PERF_EN
    chk("instr_count", int'(instr_count), done_cnt);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
